fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of a FIFO (sync or async write side) between NUM_REQ requesters.
- Requesters use a valid/ready handshake; the block drives the FIFO's wr_en/din and honours its full flag.
- A grant is held for a burst of up to BURST_MAX words, so one producer's data stays contiguous in the FIFO.
- Sits in the FIFO write-clock domain, directly in front of the FIFO.

Parameters:
DATA_WIDTH, 8, width of each requester word and of fifo_din
NUM_REQ, 4, number of requesters (2..8)
BURST_MAX, 4, maximum words accepted per grant (1..16)

Ports:
clk  input  1  write-side clock; all logic on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  bit i: requester i has a word on its data slice
req_data  input  NUM_REQ*DATA_WIDTH  flattened; requester i owns bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  bit i: word from requester i accepted this cycle
fifo_full  input  1  full flag from the FIFO write side
fifo_wr_en  output  1  FIFO write enable
fifo_din  output  DATA_WIDTH  FIFO write data
grant_id  output  clog2(NUM_REQ)  current owner index; valid while busy=1
busy  output  1  1 in GRANT state
wr_count  output  16  total words written since reset; wraps 0xFFFF->0

Behaviour:
- Reset:
  - state=IDLE, busy=0, grant_id=0, burst_cnt=0, wr_count=0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - req_ready=0 and fifo_wr_en=0 while reset is high.
  - Reset asserted mid-burst aborts the burst; the word presented in the reset cycle is not written.
- States: IDLE, GRANT.
- IDLE:
  - No transfers. req_ready=0, fifo_wr_en=0.
  - If any req_valid=1, the winner is the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - On that edge: owner<=winner, grant_id<=winner, burst_cnt<=0, go to GRANT.
  - Arbitration latency is 1 cycle: the earliest transfer is the cycle after valid is first seen in IDLE.
- GRANT, combinational outputs:
  - xfer = req_valid[owner] & ~fifo_full.
  - fifo_wr_en = xfer. req_ready[owner] = xfer. All other req_ready bits = 0.
  - fifo_din = owner's data slice at all times in GRANT. fifo_din = 0 in IDLE.
- GRANT, per edge:
  - xfer=1: wr_count++, burst_cnt++. If burst_cnt==BURST_MAX-1, release.
  - req_valid[owner]=0: release immediately; no transfer that cycle.
  - fifo_full=1 with owner valid: stall. Hold the grant and burst_cnt indefinitely; no timeout.
- Release: last_grant<=owner, go to IDLE. There is one IDLE bubble cycle between consecutive grants.
- Fairness: a requester that keeps valid asserted is served within NUM_REQ grants.
- Simultaneous events:
  - fifo_full and a dropping valid in the same GRANT cycle → release, no write.
  - New valid from other requesters during GRANT is ignored until IDLE.
- Requester contract: data must be held stable while valid=1 and ready=0. The block does not check this.
- No internal data buffering: zero-latency pass-through from req_data to fifo_din while granted.

Test Plan:
- After reset, req_valid=4'b0001, 6 words 0x10..0x15 → IDLE 1 cycle, then 0x10..0x13 written on 4 consecutive clks. Release, 1-cycle IDLE, re-grant to 0, then 0x14,0x15 written; wr_count=6.
- All 4 requesters valid continuously, BURST_MAX=4 → grant order 0,1,2,3,0. Each grant writes 4 words, a 1-cycle gap between bursts, wr_count=16 after the first round.
- Requester 2 granted, fifo_full=1 for 5 cycles after its 2nd word → fifo_wr_en=0 and req_ready=0 for those 5 cycles, grant_id stays 2. Words 3–4 are written after full drops, then release.
- Requester 1 granted, drops valid after 1 word → release next edge. last_grant=1, so with req 0 and 3 valid, req 3 wins next.
- Reset pulsed during a burst from requester 3 → busy=0, wr_count=0, no write in the reset cycle. Next grant goes to the lowest valid index.
- 65,537 single-word transfers → wr_count wraps to 1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares the single write port of a FIFO between
//   NUM_REQ valid/ready requesters. A grant is held for a burst of up to
//   BURST_MAX words so that one producer's data stays contiguous in the FIFO.
//   There is no data buffering: the owner's data passes straight to fifo_din.
//
// Ports
//   clk         write-side clock, all logic on posedge
//   reset       synchronous, active-high reset
//   req_valid   per-requester valid
//   req_data    flattened data, requester i owns [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   per-requester ready (word accepted this cycle)
//   fifo_full   FIFO full flag
//   fifo_wr_en  FIFO write enable
//   fifo_din    FIFO write data (0 while idle)
//   grant_id    current owner index, valid while busy=1
//   busy        1 while a grant is held
//   wr_count    total words written since reset, wraps at 16 bits
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_din,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic [15:0]                     wr_count
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BCW  = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [BCW-1:0]  burst_cnt;

    logic            owner_valid;
    logic            xfer;
    logic [ID_W-1:0] winner;
    logic            found;
    int unsigned     scan_idx;

    // grant_id doubles as the owner register
    assign owner_valid = req_valid[grant_id];

    // Gated by reset so a word presented in a reset cycle is never written.
    assign xfer = (state == GRANT) && owner_valid && !fifo_full && !reset;

    assign fifo_wr_en = xfer;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        fifo_din = '0;
        if (state == GRANT) begin
            fifo_din = req_data[32'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search starting just after last_grant, wrapping modulo NUM_REQ.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = 32'(last_grant) + i;
            if (scan_idx >= unsigned'(NUM_REQ)) begin
                scan_idx = scan_idx - unsigned'(NUM_REQ);
            end
            if (!found && req_valid[scan_idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            grant_id   <= '0;
            burst_cnt  <= '0;
            wr_count   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id  <= winner;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_valid) begin
                        // owner dropped valid: release with no write, even if full
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (!fifo_full) begin
                        wr_count <= wr_count + 16'd1;
                        if (burst_cnt == BCW'(BURST_MAX - 1)) begin
                            last_grant <= grant_id;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                    // full with owner valid: stall, grant and burst_cnt held
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (DATA_WIDTH=8, NUM_REQ=4, BURST_MAX=4).
//   Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] wr_count;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [7:0]  base [4];
    logic [7:0]  cnt  [4];

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .BURST_MAX  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_id   (grant_id),
        .busy       (busy),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic build_data();
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = base[i] + cnt[i];
        end
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 4; i++) cnt[i] = 8'h00;
    endtask

    // One clock cycle: drive inputs, check outputs, advance past the edge.
    task automatic cyc(input string tag, input logic [3:0] v, input logic full, input logic rst,
                       input logic exp_en, input logic [7:0] exp_din, input logic [3:0] exp_rdy,
                       input logic exp_busy, input logic [1:0] exp_gid);
        reset     = rst;
        req_valid = v;
        fifo_full = full;
        build_data();
        #1;
        check({tag, "_wr_en"}, 32'(fifo_wr_en), 32'(exp_en));
        check({tag, "_din"},   32'(fifo_din),   32'(exp_din));
        check({tag, "_ready"}, 32'(req_ready),  32'(exp_rdy));
        check({tag, "_busy"},  32'(busy),       32'(exp_busy));
        if (exp_busy) check({tag, "_gid"}, 32'(grant_id), 32'(exp_gid));
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) cnt[i] = cnt[i] + 8'h01;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_gid",   32'(grant_id),   32'd0);
        check("rst_count", 32'(wr_count),   32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_ready", 32'(req_ready),  32'd0);
        reset = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) base[i] = 8'h00;
        clr_cnt();

        // 1: single requester, 6 words -> burst of 4, gap, burst of 2
        do_reset();
        base[0] = 8'h10;
        clr_cnt();
        cyc("t1_idle", 4'b0001, 0, 0, 0, 8'h00, 4'b0000, 0, 0);
        for (int k = 0; k < 4; k++)
            cyc("t1_wa", 4'b0001, 0, 0, 1, 8'(8'h10 + k), 4'b0001, 1, 0);
        cyc("t1_gap", 4'b0001, 0, 0, 0, 8'h00, 4'b0000, 0, 0);
        for (int k = 4; k < 6; k++)
            cyc("t1_wb", 4'b0001, 0, 0, 1, 8'(8'h10 + k), 4'b0001, 1, 0);
        cyc("t1_drop", 4'b0000, 0, 0, 0, 8'h16, 4'b0000, 1, 0);
        #1;
        check("t1_count", 32'(wr_count), 32'd6);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // 2: all valid -> order 0,1,2,3,0, 4 words each, 1-cycle gaps
        do_reset();
        base[0] = 8'h00; base[1] = 8'h40; base[2] = 8'h80; base[3] = 8'hC0;
        clr_cnt();
        for (int g = 0; g < 5; g++) begin
            cyc("t2_gap", 4'b1111, 0, 0, 0, 8'h00, 4'b0000, 0, 0);
            for (int k = 0; k < 4; k++)
                cyc("t2_w", 4'b1111, 0, 0, 1, 8'(base[g % 4] + (g / 4) * 4 + k),
                    4'(1 << (g % 4)), 1, 2'(g % 4));
            if (g == 3) check("t2_count16", 32'(wr_count), 32'd16);
        end
        check("t2_count20", 32'(wr_count), 32'd20);

        // 3: requester 2 stalls on full for 5 cycles after its 2nd word
        do_reset();
        base[2] = 8'h30;
        clr_cnt();
        cyc("t3_idle", 4'b0100, 0, 0, 0, 8'h00, 4'b0000, 0, 0);
        cyc("t3_w1", 4'b0100, 0, 0, 1, 8'h30, 4'b0100, 1, 2);
        cyc("t3_w2", 4'b0100, 0, 0, 1, 8'h31, 4'b0100, 1, 2);
        for (int k = 0; k < 5; k++)
            cyc("t3_stall", 4'b0100, 1, 0, 0, 8'h32, 4'b0000, 1, 2);
        cyc("t3_w3", 4'b0100, 0, 0, 1, 8'h32, 4'b0100, 1, 2);
        cyc("t3_w4", 4'b0100, 0, 0, 1, 8'h33, 4'b0100, 1, 2);
        cyc("t3_rel", 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0, 0);
        check("t3_count", 32'(wr_count), 32'd4);

        // 4: requester 1 drops after 1 word; then 3 beats 0 (last_grant=1)
        base[1] = 8'h50; base[3] = 8'h70;
        clr_cnt();
        cyc("t4_idle", 4'b0010, 0, 0, 0, 8'h00, 4'b0000, 0, 0);
        cyc("t4_w1", 4'b0010, 0, 0, 1, 8'h50, 4'b0010, 1, 1);
        cyc("t4_drop", 4'b1001, 0, 0, 0, 8'h51, 4'b0000, 1, 1);
        cyc("t4_idle2", 4'b1001, 0, 0, 0, 8'h00, 4'b0000, 0, 0);
        cyc("t4_w3", 4'b1001, 0, 0, 1, 8'h70, 4'b1000, 1, 3);
        // owner drops valid while FIFO is full: release, no write
        cyc("t4_dropfull", 4'b0000, 1, 0, 0, 8'h71, 4'b0000, 1, 3);
        cyc("t4_end", 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0, 0);
        check("t4_count", 32'(wr_count), 32'd6);

        // 5: reset mid-burst from requester 3
        base[3] = 8'h90; base[1] = 8'h50;
        clr_cnt();
        cyc("t5_idle", 4'b1000, 0, 0, 0, 8'h00, 4'b0000, 0, 0);
        cyc("t5_w1", 4'b1000, 0, 0, 1, 8'h90, 4'b1000, 1, 3);
        cyc("t5_w2", 4'b1000, 0, 0, 1, 8'h91, 4'b1000, 1, 3);
        cyc("t5_rst", 4'b1000, 0, 1, 0, 8'h92, 4'b0000, 1, 3);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_count", 32'(wr_count), 32'd0);
        check("t5_gid", 32'(grant_id), 32'd0);
        cyc("t5_idle2", 4'b1010, 0, 0, 0, 8'h00, 4'b0000, 0, 0);
        cyc("t5_w", 4'b1010, 0, 0, 1, 8'h50, 4'b0010, 1, 1);
        cyc("t5_drop", 4'b0000, 0, 0, 0, 8'h51, 4'b0000, 1, 1);
        check("t5_count1", 32'(wr_count), 32'd1);

        // 6: 65537 writes -> wr_count wraps to 1
        do_reset();
        req_valid = 4'b0001;
        repeat (16384 * 5) @(posedge clk);
        #1;
        check("t6_wrap0", 32'(wr_count), 32'd0);
        check("t6_wrap_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("t6_wrap1", 32'(wr_count), 32'd1);
        check("t6_end_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
